// File: rtl/stream_mux.sv
// stream_mux: registered N-way valid/ready selector with fixed-select or round-robin arbitration
module stream_mux #(
  parameter int WIDTH  = 32,
  parameter int NUM_CH = 4,
  parameter int SEL_W  = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    mode,
  input  logic [SEL_W-1:0]        sel,
  input  logic [NUM_CH-1:0]       in_valid,
  input  logic [NUM_CH*WIDTH-1:0] in_data,
  output logic [NUM_CH-1:0]       in_ready,
  output logic                    out_valid,
  output logic [WIDTH-1:0]        out_data,
  output logic [SEL_W-1:0]        out_ch,
  input  logic                    out_ready
);
  logic [SEL_W-1:0] ptr, hi_idx, lo_idx, idx;
  logic             hi_hit, lo_hit, fx_hit, hit, load_en, xfer;
  logic [WIDTH-1:0] nxt;
  // Round-robin split: lowest valid index above ptr wins, else lowest at or below ptr.
  always_comb begin
    hi_hit = 1'b0;
    lo_hit = 1'b0;
    hi_idx = '0;
    lo_idx = '0;
    fx_hit = 1'b0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (in_valid[i] && SEL_W'(i) > ptr) begin
        hi_hit = 1'b1;
        hi_idx = SEL_W'(i);
      end
      if (in_valid[i] && SEL_W'(i) <= ptr) begin
        lo_hit = 1'b1;
        lo_idx = SEL_W'(i);
      end
      if (in_valid[i] && sel == SEL_W'(i)) fx_hit = 1'b1;
    end
  end
  assign hit     = mode ? (hi_hit | lo_hit) : fx_hit;
  assign idx     = mode ? (hi_hit ? hi_idx : lo_idx) : sel;
  assign load_en = !out_valid || out_ready;
  always_comb begin
    in_ready = '0;
    nxt      = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      in_ready[i] = rst_n && hit && load_en && idx == SEL_W'(i);
      if (in_ready[i]) nxt = in_data[i*WIDTH +: WIDTH];
    end
  end
  assign xfer = |in_ready;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_ch    <= '0;
      ptr       <= SEL_W'(NUM_CH - 1);
    end else if (xfer) begin
      out_valid <= 1'b1;
      out_data  <= nxt;
      out_ch    <= idx;
      ptr       <= idx;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_stream_mux.sv
// tb_stream_mux: random and directed checks of a 4-channel and a 3-channel stream_mux against a queue-free reference model
module tb_stream_mux;
  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         mode_a = 1'b0, mode_b = 1'b0;
  logic [1:0]   sel_a = '0, sel_b = '0;
  logic [3:0]   iv_a = '0;
  logic [2:0]   iv_b = '0;
  logic [127:0] id_a = '0;
  logic [95:0]  id_b = '0;
  logic         or_a = 1'b0, or_b = 1'b0;
  logic [3:0]   ir_a;
  logic [2:0]   ir_b;
  logic         ov_a, ov_b;
  logic [31:0]  od_a, od_b;
  logic [1:0]   oc_a, oc_b;

  int errs = 0, checks = 0;
  logic        mv[2];
  logic [31:0] md[2];
  int          mc[2], mp[2];
  logic [1:0]  seq[8];

  always #5 clk = ~clk;

  stream_mux #(.WIDTH(32), .NUM_CH(4), .SEL_W(2)) dut_a (
    .clk(clk), .rst_n(rst_n), .mode(mode_a), .sel(sel_a), .in_valid(iv_a), .in_data(id_a),
    .in_ready(ir_a), .out_valid(ov_a), .out_data(od_a), .out_ch(oc_a), .out_ready(or_a));

  stream_mux #(.WIDTH(32), .NUM_CH(3), .SEL_W(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .mode(mode_b), .sel(sel_b), .in_valid(iv_b), .in_data(id_b),
    .in_ready(ir_b), .out_valid(ov_b), .out_data(od_b), .out_ch(oc_b), .out_ready(or_b));

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Channel granted by the arbitration rules, or -1 when nothing transfers.
  function automatic int grant(int n, logic m, logic [1:0] s, logic [3:0] v, int p);
    if (!m) return (int'(s) < n && v[s]) ? int'(s) : -1;
    for (int k = 1; k <= n; k++) if (v[(p + k) % n]) return (p + k) % n;
    return -1;
  endfunction

  task automatic check_outs(input string tag);
    chk({tag, "_a_valid"}, 64'(ov_a), 64'(mv[0]));
    chk({tag, "_a_data"},  64'(od_a), 64'(md[0]));
    chk({tag, "_a_ch"},    64'(oc_a), 64'(mc[0]));
    chk({tag, "_b_valid"}, 64'(ov_b), 64'(mv[1]));
    chk({tag, "_b_data"},  64'(od_b), 64'(md[1]));
    chk({tag, "_b_ch"},    64'(oc_b), 64'(mc[1]));
  endtask

  task automatic model_reset();
    for (int j = 0; j < 2; j++) begin
      mv[j] = 1'b0;
      md[j] = '0;
      mc[j] = 0;
    end
    mp[0] = 3;
    mp[1] = 2;
  endtask

  task automatic do_reset();
    iv_a = 4'hF;
    iv_b = 3'h7;
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("rst_a_ready", 64'(ir_a), 64'h0);
    chk("rst_b_ready", 64'(ir_b), 64'h0);
    check_outs("rst");
    #1 rst_n = 1'b1;
  endtask

  task automatic step(input string tag);
    int g0, g1;
    #1;
    g0 = (!mv[0] || or_a) ? grant(4, mode_a, sel_a, iv_a, mp[0]) : -1;
    g1 = (!mv[1] || or_b) ? grant(3, mode_b, sel_b, {1'b0, iv_b}, mp[1]) : -1;
    chk({tag, "_a_ready"}, 64'(ir_a), g0 >= 0 ? 64'(1) << g0 : 64'h0);
    chk({tag, "_b_ready"}, 64'(ir_b), g1 >= 0 ? 64'(1) << g1 : 64'h0);
    @(posedge clk);
    if (g0 >= 0) begin
      mv[0] = 1'b1; md[0] = id_a[g0*32 +: 32]; mc[0] = g0; mp[0] = g0;
    end else if (or_a) mv[0] = 1'b0;
    if (g1 >= 0) begin
      mv[1] = 1'b1; md[1] = id_b[g1*32 +: 32]; mc[1] = g1; mp[1] = g1;
    end else if (or_b) mv[1] = 1'b0;
    #1;
    check_outs(tag);
  endtask

  initial begin
    for (int i = 0; i < 4; i++) id_a[i*32 +: 32] = 32'hCAFE0000 + 32'(i);
    for (int i = 0; i < 3; i++) id_b[i*32 +: 32] = 32'hBEEF0000 + 32'(i);
    #3;
    do_reset();
    // Fixed select of ch2; B offered an out-of-range select.
    mode_a = 1'b0; sel_a = 2'd2; iv_a = 4'b0100; or_a = 1'b1;
    mode_b = 1'b0; sel_b = 2'd3; iv_b = 3'b111; or_b = 1'b1;
    step("fix");
    chk("fix_data", 64'(od_a), 64'hCAFE0002);
    chk("fix_ch", 64'(oc_a), 64'd2);
    chk("sel3_valid", 64'(ov_b), 64'd0);
    // Stall for three cycles, then resume with a fresh ch2 word.
    iv_a = 4'b1111; or_a = 1'b0;
    step("stall_load");
    id_a[2*32 +: 32] = 32'hCAFE1002;
    for (int i = 0; i < 3; i++) step("stall");
    chk("stall_held", 64'(od_a), 64'hCAFE0002);
    or_a = 1'b1;
    step("resume");
    chk("resume_data", 64'(od_a), 64'hCAFE1002);
    // Round-robin from reset with every channel valid.
    do_reset();
    mode_a = 1'b1; iv_a = 4'b1111; or_a = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step("rr");
      seq[i] = oc_a;
    end
    for (int i = 0; i < 8; i++) chk("rr_seq", 64'(seq[i]), 64'(i % 4));
    // ch1 granted last, then only ch1 and ch3 valid.
    mode_a = 1'b0; sel_a = 2'd1; iv_a = 4'b0010;
    step("pre1010");
    mode_a = 1'b1; iv_a = 4'b1010;
    for (int i = 0; i < 4; i++) begin
      step("rr1010");
      chk("rr1010_ch", 64'(oc_a), i % 2 == 0 ? 64'd3 : 64'd1);
    end
    // Randomized traffic on both instances.
    for (int n = 0; n < 400; n++) begin
      mode_a = 1'($urandom); sel_a = 2'($urandom); iv_a = 4'($urandom);
      mode_b = 1'($urandom); sel_b = 2'($urandom); iv_b = 3'($urandom);
      or_a = $urandom_range(0, 3) != 0; or_b = $urandom_range(0, 3) != 0;
      for (int i = 0; i < 4; i++) id_a[i*32 +: 32] = $urandom;
      for (int i = 0; i < 3; i++) id_b[i*32 +: 32] = $urandom;
      step("rand");
    end
    // Hold a word in B, then reset asynchronously mid-cycle.
    mode_b = 1'b0; sel_b = 2'd1; iv_b = 3'b010; or_b = 1'b0;
    step("hold_b");
    chk("hold_b_valid", 64'(ov_b), 64'd1);
    do_reset();
    chk("async_b_valid", 64'(ov_b), 64'd0);
    mode_b = 1'b1; iv_b = 3'b111; or_b = 1'b1;
    mode_a = 1'b1; iv_a = 4'b1111; or_a = 1'b1;
    step("post_rst");
    chk("post_rst_b_ch", 64'(oc_b), 64'd0);
    chk("post_rst_a_ch", 64'(oc_a), 64'd0);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
